// File: rtl/chip8_pkg.sv
// ============================================================================
// Module   : chip8_pkg
// Desc     : Shared CHIP-8 constants and the sprite sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip8_pkg;

  localparam int SCREEN_W       = 64;
  localparam int SCREEN_H       = 32;
  localparam int ADDR_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DRAW   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } sprite_state_t;

endpackage

`default_nettype wire

// File: rtl/chip8_sprite_engine.sv
// ============================================================================
// Module   : chip8_sprite_engine
// Desc     : DXYN sequencer: fetches N sprite rows from memory, strobes each
//            into the framebuffer stage and OR-accumulates collisions into VF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int MEM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    vx,
  input  logic [7:0]                    vy,
  input  logic [3:0]                    n,
  input  logic [ADDR_W-1:0]             i_reg,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    vf_out,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [7:0]                    mem_data,
  output logic                          draw,
  output logic [$clog2(SCREEN_W)-1:0]   x,
  output logic [$clog2(SCREEN_H)-1:0]   y,
  output logic [3:0]                    row_index,
  output logic [7:0]                    sprite_data,
  input  logic                          collision_in
);

  localparam logic [1:0] C_WAIT_LAST = 2'(MEM_LAT - 1);

  sprite_state_t r_state, w_state_next;

  logic [1:0]                  r_wait;
  logic [3:0]                  r_row;
  logic [3:0]                  r_n;
  logic [ADDR_W-1:0]           r_base;
  logic [$clog2(SCREEN_W)-1:0] r_x;
  logic [$clog2(SCREEN_H)-1:0] r_y;
  logic [7:0]                  r_sprite;
  logic                        r_acc;
  logic [7:0]                  r_vf;
  logic                        w_last_row;
  logic                        w_wait_last;
  logic                        w_unused;

  // Coordinates wrap by truncation; the dropped high bits are intentionally ignored.
  assign w_unused    = ^{vx[7:$clog2(SCREEN_W)], vy[7:$clog2(SCREEN_H)]};
  assign w_last_row  = (r_row == (r_n - 4'd1));
  assign w_wait_last = (r_wait == C_WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = (n == 4'd0) ? DONE : FETCH;
      FETCH:   w_state_next = WAIT;
      WAIT:    if (w_wait_last) w_state_next = DRAW;
      DRAW:    w_state_next = SETTLE;
      SETTLE:  w_state_next = w_last_row ? DONE : FETCH;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are masked by reset so a mid-draw reset never leaks a partial pulse.
  always_comb begin
    busy   = (r_state != IDLE);
    mem_rd = (r_state == FETCH) && !reset;
    draw   = (r_state == DRAW)  && !reset;
    done   = (r_state == DONE)  && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait   <= 2'd0;
      r_row    <= 4'd0;
      r_n      <= 4'd0;
      r_base   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_sprite <= 8'd0;
      r_acc    <= 1'b0;
      r_vf     <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n    <= n;
            r_base <= i_reg;
            r_x    <= vx[$clog2(SCREEN_W)-1:0];
            r_y    <= vy[$clog2(SCREEN_H)-1:0];
            r_row  <= 4'd0;
            r_acc  <= 1'b0;
            r_vf   <= 8'd0;
          end
        end
        FETCH: r_wait <= 2'd0;
        WAIT: begin
          r_wait <= r_wait + 2'd1;
          if (w_wait_last) r_sprite <= mem_data;
        end
        SETTLE: begin
          r_acc <= r_acc | collision_in;
          if (w_last_row) r_vf  <= {7'd0, r_acc | collision_in};
          else            r_row <= r_row + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_base + ADDR_W'(r_row);
  assign x           = r_x;
  assign y           = r_y;
  assign row_index   = r_row;
  assign sprite_data = r_sprite;
  assign vf_out      = r_vf;

endmodule

`default_nettype wire

// File: tb/tb_chip8_sprite_engine.sv
// ============================================================================
// Module   : tb_chip8_sprite_engine
// Desc     : Scoreboard bench for chip8_sprite_engine at MEM_LAT=1 and MEM_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip8_sprite_engine;
  import chip8_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start1, start3;
  logic [7:0]    vx1, vy1, vx3, vy3;
  logic [3:0]    n1, n3;
  logic [AW-1:0] i1, i3;
  logic          busy1, done1, rd1, draw1, coll1;
  logic          busy3, done3, rd3, draw3, coll3;
  logic [7:0]    vf1, md1, spr1, vf3, md3, spr3;
  logic [AW-1:0] ma1, ma3;
  logic [5:0]    x1, x3;
  logic [4:0]    y1, y3;
  logic [3:0]    row1, row3;

  chip8_sprite_engine #(.ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .vx(vx1), .vy(vy1), .n(n1), .i_reg(i1),
    .busy(busy1), .done(done1), .vf_out(vf1), .mem_rd(rd1), .mem_addr(ma1),
    .mem_data(md1), .draw(draw1), .x(x1), .y(y1), .row_index(row1),
    .sprite_data(spr1), .collision_in(coll1));

  chip8_sprite_engine #(.ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .vx(vx3), .vy(vy3), .n(n3), .i_reg(i3),
    .busy(busy3), .done(done3), .vf_out(vf3), .mem_rd(rd3), .mem_addr(ma3),
    .mem_data(md3), .draw(draw3), .x(x3), .y(y3), .row_index(row3),
    .sprite_data(spr3), .collision_in(coll3));

  // Memories return zero when not read, so an early latch picks up a wrong byte.
  logic [7:0] mem [4096];
  logic [7:0] p3 [3];
  always @(posedge clk) md1 <= rd1 ? mem[ma1] : 8'h00;
  always @(posedge clk) begin
    p3[0] <= rd3 ? mem[ma3] : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign md3   = p3[2];
  assign coll3 = 1'b0;

  logic [63:0] fb [32];
  logic [63:0] m1;
  logic [4:0]  py1;

  function automatic logic [63:0] row_mask(input logic [5:0] xs, input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) m[6'(xs + 6'(j))] = s[7-j];
    return m;
  endfunction

  function automatic int fb_pixels();
    int c;
    c = 0;
    for (int r = 0; r < 32; r++) c += $countones(fb[r]);
    return c;
  endfunction

  assign m1  = row_mask(x1, spr1);
  assign py1 = y1 + {1'b0, row1};

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) fb[r] <= '0;
      coll1 <= 1'b0;
    end else if (draw1) begin
      fb[py1] <= fb[py1] ^ m1;
      coll1   <= |(fb[py1] & m1);
    end
  end

  typedef struct { int cyc; logic [3:0] row; logic [7:0] data; logic [5:0] x; logic [4:0] y; } draw_t;
  typedef struct { int cyc; logic [7:0] vf; } done_t;

  logic [AW-1:0] aq1 [$], aq3 [$];
  draw_t         dq1 [$], dq3 [$];
  done_t         nq1 [$], nq3 [$];
  bit            was_done [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit sel, input int t, input int lat, input logic [3:0] n,
                          input logic [AW-1:0] ia, input logic [5:0] ex, input logic [4:0] ey,
                          input logic [7:0] evf);
    draw_t d;
    done_t e;
    logic [AW-1:0] a;
    for (int r = 0; r < int'(n); r++) begin
      a = ia + AW'(r);
      d.cyc = t + 1 + r * (3 + lat) + 1 + lat;
      d.row = 4'(r); d.data = mem[a]; d.x = ex; d.y = ey;
      if (sel) begin aq3.push_back(a); dq3.push_back(d); end
      else     begin aq1.push_back(a); dq1.push_back(d); end
    end
    e.cyc = t + 1 + int'(n) * (3 + lat);
    e.vf  = evf;
    if (sel) nq3.push_back(e);
    else     nq1.push_back(e);
  endtask

  task automatic mon(input bit sel);
    logic rd, dr, dn, bz;
    logic [AW-1:0] ma;
    logic [3:0] row;
    logic [7:0] spr, vf;
    logic [5:0] xx;
    logic [4:0] yy;
    draw_t d;
    done_t e;
    string s;
    if (sel) begin rd = rd3; dr = draw3; dn = done3; bz = busy3; ma = ma3; row = row3; spr = spr3; vf = vf3; xx = x3; yy = y3; s = "u3"; end
    else     begin rd = rd1; dr = draw1; dn = done1; bz = busy1; ma = ma1; row = row1; spr = spr1; vf = vf1; xx = x1; yy = y1; s = "u1"; end
    if (rd) begin
      if ((sel ? aq3.size() : aq1.size()) == 0) check({s, "_rd_extra"}, 1, 0);
      else check({s, "_rd_addr"}, 32'(ma), 32'(sel ? aq3.pop_front() : aq1.pop_front()));
    end
    if (dr) begin
      if ((sel ? dq3.size() : dq1.size()) == 0) check({s, "_draw_extra"}, 1, 0);
      else begin
        if (sel) d = dq3.pop_front();
        else     d = dq1.pop_front();
        check({s, "_draw_cyc"}, cyc, d.cyc);
        check({s, "_draw_row"}, 32'(row), 32'(d.row));
        check({s, "_draw_data"}, 32'(spr), 32'(d.data));
        check({s, "_draw_xy"}, {xx, yy}, {d.x, d.y});
      end
    end
    if (dn) begin
      if ((sel ? nq3.size() : nq1.size()) == 0) check({s, "_done_extra"}, 1, 0);
      else begin
        if (sel) e = nq3.pop_front();
        else     e = nq1.pop_front();
        check({s, "_done_cyc"}, cyc, e.cyc);
        check({s, "_done_vf"}, 32'(vf), 32'(e.vf));
      end
    end
    if (was_done[sel]) check({s, "_busy_fall"}, 32'(bz), 0);
    was_done[sel] = dn;
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  // Waits for done (bounded), then steps into the following IDLE cycle.
  task automatic wait_done(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sel ? done3 : done1) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!seen) begin
      check(sel ? "u3_timeout" : "u1_timeout", 0, 1);
      aq1.delete(); dq1.delete(); nq1.delete();
      aq3.delete(); dq3.delete(); nq3.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic run_op(input bit sel, input logic [7:0] vx, input logic [7:0] vy,
                        input logic [3:0] n, input logic [AW-1:0] ia, input logic [5:0] ex,
                        input logic [4:0] ey, input logic [7:0] evf);
    if (sel) begin vx3 = vx; vy3 = vy; n3 = n; i3 = ia; start3 = 1'b1; end
    else     begin vx1 = vx; vy1 = vy; n1 = n; i1 = ia; start1 = 1'b1; end
    push_exp(sel, cyc, sel ? 3 : 1, n, ia, ex, ey, evf);
    @(negedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    check(sel ? "u3_busy_rise" : "u1_busy_rise", 32'(sel ? busy3 : busy1), 1);
    wait_done(sel);
  endtask

  typedef struct { logic [7:0] vx; logic [7:0] vy; logic [3:0] n; logic [AW-1:0] ia;
                   logic [5:0] ex; logic [4:0] ey; logic [7:0] evf; int epix; } vec_t;
  vec_t vt [4];

  initial begin
    logic [11:0] av;
    int t;
    vt[0] = '{8'd10, 8'd5,  4'd3, 12'h300, 6'd10, 5'd5, 8'h00, 10};
    vt[1] = '{8'd10, 8'd5,  4'd3, 12'h300, 6'd10, 5'd5, 8'h01, 0};
    vt[2] = '{8'd70, 8'd40, 4'd2, 12'hFFF, 6'd6,  5'd8, 8'h00, 6};
    vt[3] = '{8'd1,  8'd2,  4'd0, 12'h123, 6'd1,  5'd2, 8'h00, 6};
    for (int a = 0; a < 4096; a++) begin
      av = 12'(a);
      mem[a] = ({av[3:0], av[7:4]} ^ 8'hC3) | 8'h01;
    end
    mem[12'h300] = 8'hF0; mem[12'h301] = 8'h90; mem[12'h302] = 8'hF0;
    mem[12'hFFF] = 8'h81; mem[12'h000] = 8'h3C;

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    vx1 = 0; vy1 = 0; n1 = 0; i1 = 0; vx3 = 0; vy3 = 0; n3 = 0; i3 = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_u1", {busy1, done1, draw1, rd1, ma1, x1, y1, row1, spr1, vf1}, 0);
    check("reset_u3", {busy3, done3, draw3, rd3, ma3, x3, y3, row3, spr3, vf3}, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, vt[i].vx, vt[i].vy, vt[i].n, vt[i].ia, vt[i].ex, vt[i].ey, vt[i].evf);
      check("vf_held", 32'(vf1), 32'(vt[i].evf));
      check("fb_pixels", fb_pixels(), vt[i].epix);
    end

    // Reset during the second row's WAIT.
    t = cyc;
    vx1 = 0; vy1 = 0; n1 = 4'd3; i1 = 12'h300; start1 = 1'b1;
    push_exp(1'b0, t, 1, 4'd3, 12'h300, 6'd0, 5'd0, 8'h00);
    @(negedge clk); #1;
    start1 = 1'b0;
    repeat (5) begin @(negedge clk); #1; end
    check("mid_wait_busy", {busy1, rd1, draw1}, 3'b100);
    reset = 1'b1;
    aq1.delete(); dq1.delete(); nq1.delete();
    @(negedge clk); #1;
    check("reset_mid", {busy1, done1, draw1, rd1, ma1, x1, y1, row1, spr1, vf1}, 0);
    reset = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    run_op(1'b0, vt[0].vx, vt[0].vy, vt[0].n, vt[0].ia, vt[0].ex, vt[0].ey, 8'h00);
    check("post_reset_pixels", fb_pixels(), 10);

    // MEM_LAT=3 with start pulses while busy.
    t = cyc;
    vx3 = 8'd3; vy3 = 8'd4; n3 = 4'd1; i3 = 12'h010; start3 = 1'b1;
    push_exp(1'b1, t, 3, 4'd1, 12'h010, 6'd3, 5'd4, 8'h00);
    @(negedge clk); #1;
    start3 = 1'b0;
    @(negedge clk); #1;
    vx3 = 8'd63; vy3 = 8'd31; n3 = 4'd15; i3 = 12'h777; start3 = 1'b1;
    @(negedge clk); #1;
    start3 = 1'b0;
    @(negedge clk); #1;
    start3 = 1'b1;
    @(negedge clk); #1;
    start3 = 1'b0;
    wait_done(1'b1);
    repeat (5) begin @(negedge clk); #1; end
    check("u3_idle_after", {busy3, vf3}, 0);

    check("leftover_u1", aq1.size() + dq1.size() + nq1.size(), 0);
    check("leftover_u3", aq3.size() + dq3.size() + nq3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chip8_sprite_engine.md
# chip8_sprite_engine

Sequencer for the CHIP-8 DXYN (draw sprite) instruction. On a start request it fetches N sprite bytes from main memory at I, I+1, …, I+N-1. It presents each byte, one row at a time, to the framebuffer XOR/collision stage, and OR-accumulates that stage's per-row collision flag into a VF result. It sits between the instruction decoder/executor and the framebuffer stage, and owns the memory read port for the duration of the draw.

## Interface
Parameters:
- ADDR_W, 12: memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- MEM_LAT, 1: memory read latency in cycles, legal range 1..3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle draw request; sampled only in IDLE.
- vx  in  8  VX register value, captured at start.
- vy  in  8  VY register value, captured at start.
- n  in  4  sprite height in rows, captured at start.
- i_reg  in  ADDR_W  I register value, captured at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the draw completes.
- vf_out  out  8  collision result, 8'h01 or 8'h00; held until the next accepted start.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  8  read data, valid MEM_LAT cycles after mem_rd.
- draw  out  1  one-cycle draw strobe to the framebuffer stage.
- x  out  6  vx[5:0], held for the whole operation.
- y  out  5  vy[4:0], held for the whole operation.
- row_index  out  4  current row, 0..n-1.
- sprite_data  out  8  latched sprite byte for the current row.
- collision_in  in  1  framebuffer collision flag, registered on the draw edge.

## Operation
- States: IDLE, FETCH, WAIT, DRAW, SETTLE, DONE.
- **IDLE**
  - On start: capture vx, vy, n, i_reg; clear row counter and vf accumulator.
  - Go to FETCH, or to DONE if n==0.
- **FETCH**: mem_rd=1, mem_addr=(i_reg+row) mod 2^ADDR_W; go to WAIT.
- **WAIT**: count MEM_LAT cycles. In the final WAIT cycle, latch mem_data into sprite_data; go to DRAW.
- **DRAW**: draw=1 with x, y, row_index=row, sprite_data stable; go to SETTLE.
- **SETTLE**
  - The framebuffer output and collision flag are now updated.
  - acc |= collision_in.
  - If row==n-1, go to DONE; else row++ and go to FETCH.
  - This cycle guarantees the next row's draw sees the updated framebuffer.
- **DONE**: done=1, vf_out={7'b0,acc}; go to IDLE.
- Coordinate wrap:
  - Start coordinates wrap modulo 64/32 via truncation.
  - Per-row vertical wrap and per-pixel horizontal wrap are the framebuffer stage's job; this block never clips.
- n==0: no fetch and no draw; done pulses with vf_out=0.
- start while busy: ignored, no effect on captured operands.
- mem_rd, draw and done are combinational decodes of the state register, so they are glitch-free relative to clk.

## Timing
- Reset values: busy=0, done=0, draw=0, mem_rd=0, mem_addr=0, x=0, y=0, row_index=0, sprite_data=0, vf_out=0; state IDLE.
- Reset mid-operation: next edge returns to IDLE. draw and mem_rd are low from the first reset cycle; no partial done pulse.
- Start accepted at edge T. busy rises at T+1, which is the first FETCH cycle.
- Cycles per row: 3+MEM_LAT (FETCH, MEM_LAT×WAIT, DRAW, SETTLE).
- done is high at cycle T+1+n·(3+MEM_LAT); for n==0 it is high at T+1.
- busy falls in the cycle after done.
- vf_out updates in the DONE cycle, when done is high.
- Back-to-back operation: start may be asserted in the cycle after DONE (IDLE) and is accepted there.
- row_index and sprite_data stay stable from DRAW through SETTLE.

## Structure
- Shared chip8_pkg holds:
  - SCREEN_W=64 and SCREEN_H=32.
  - ADDR_W default.
  - the sprite_state_t enum (IDLE, FETCH, WAIT, DRAW, SETTLE, DONE).
- The framebuffer stage already imports SCREEN_W and SCREEN_H from chip8_pkg.
- Single module, no sub-module. The MEM_LAT wait counter is a 2-bit register inside this module.

## Test plan
- n=3, i_reg=0x300, vx=10, vy=5, blank screen, MEM_LAT=1 → mem_addr reads 0x300/0x301/0x302 with draw pulses at T+3, T+7, T+11; x=10, y=5; done at T+13; vf_out=0x01 never set, so vf_out=0x00.
- Same sprite drawn twice over a bench framebuffer model → second draw gives vf_out=0x01 and the screen returns to blank.
- vx=70, vy=40 → x=6, y=8. i_reg=0xFFF, n=2 → addresses 0xFFF then 0x000.
- n=0 → no mem_rd, no draw; done at T+1; vf_out=0x00.
- reset asserted during the second row's WAIT → IDLE next cycle; busy=0, draw never pulses again; a subsequent start runs normally.
- MEM_LAT=3, n=1 → data latched 3 cycles after mem_rd; done at T+7. start pulses while busy are ignored.
